conv_filter_sequencer: RTL and testbench

- Controls the convolution filter. Holds a 25-entry (5x5) coefficient bank written by the host.
- On `start`, it loads the mask into the filter, then streams N back-to-back frames from a pixel source into the filter.
- It frames the filter output as a valid/SOF stream and reports done, underrun and drain-timeout status.
- Sits between the host/DMA pixel source and the `convolutionFilter` instance.

---
 rtl/conv_seq_pkg.sv | 20 ++
 rtl/conv_out_framer.sv | 77 +++++++
 rtl/conv_filter_sequencer.sv | 179 +++++++++++++++++
 tb/tb_conv_filter_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_seq_pkg.sv
// rtl/conv_seq_pkg.sv - shared types and constants for the convolution filter sequencer
package conv_seq_pkg;

  localparam int NUM_COEFFS  = 25;
  localparam int COEFF_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOAD_GAP,
    STREAM,
    DRAIN
  } seq_state_e;

  // Pixel counters must hold (w+1)*(h+1)-1 for the largest image.
  function automatic int pix_cnt_width(input int dim_width);
    return 2 * dim_width;
  endfunction

endpackage

// File: rtl/conv_out_framer.sv
// rtl/conv_out_framer.sv - frames filter output into valid/SOF pixels and counts completed frames
module conv_out_framer #(
  parameter int DIM_WIDTH = 10,
  parameter int PW        = conv_seq_pkg::pix_cnt_width(DIM_WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  input  logic          i_clear,
  input  logic [PW-1:0] i_total_m1,
  input  logic          i_sync,
  input  logic [7:0]    i_data,
  output logic          o_valid,
  output logic          o_sof,
  output logic [7:0]    o_data,
  output logic          o_active,
  output logic          o_start,
  output logic [7:0]    o_frames_done
);
  import conv_seq_pkg::*;

  logic          r_active;
  logic [PW-1:0] r_cnt;
  logic [7:0]    r_frames;
  logic          r_valid;
  logic          r_sof;
  logic [7:0]    r_data;

  logic          w_start;
  logic          w_emit;
  logic [PW-1:0] w_idx;

  // A sync pulse inside an active frame is ignored; one right after the last pixel starts the next.
  assign w_start = i_en && !r_active && i_sync;
  assign w_emit  = w_start || (i_en && r_active);
  assign w_idx   = w_start ? '0 : r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_frames <= '0;
      r_valid  <= 1'b0;
      r_sof    <= 1'b0;
      r_data   <= '0;
    end else begin
      r_valid <= w_emit;
      r_sof   <= w_start;
      r_data  <= w_emit ? i_data : 8'd0;
      if (i_clear) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
        r_frames <= '0;
      end else if (w_emit) begin
        if (w_idx == i_total_m1) begin
          r_active <= 1'b0;
          r_cnt    <= '0;
          r_frames <= r_frames + 8'd1;
        end else begin
          r_active <= 1'b1;
          r_cnt    <= w_idx + PW'(1);
        end
      end else if (!i_en) begin
        r_active <= 1'b0;
        r_cnt    <= '0;
      end
    end
  end

  assign o_valid       = r_valid;
  assign o_sof         = r_sof;
  assign o_data        = r_data;
  assign o_active      = r_active;
  assign o_start       = w_start;
  assign o_frames_done = r_frames;

endmodule

// File: rtl/conv_filter_sequencer.sv
// rtl/conv_filter_sequencer.sv - loads the 5x5 mask, streams N frames into the filter, frames its output
module conv_filter_sequencer #(
  parameter int NUM_COEFFS    = conv_seq_pkg::NUM_COEFFS,
  parameter int COEFF_WIDTH   = conv_seq_pkg::COEFF_WIDTH,
  parameter int DIM_WIDTH     = 10,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [4:0]             cfg_addr,
  input  logic [COEFF_WIDTH-1:0] cfg_wdata,
  input  logic                   start,
  input  logic [7:0]             num_frames,
  input  logic [DIM_WIDTH-1:0]   img_width_m1,
  input  logic [DIM_WIDTH-1:0]   img_height_m1,
  input  logic                   src_valid,
  input  logic [7:0]             src_data,
  output logic                   src_ready,
  output logic                   filt_config_load,
  output logic [COEFF_WIDTH-1:0] filt_coeff_in,
  output logic                   filt_frame_sync_in,
  output logic [7:0]             filt_data_in,
  output logic [DIM_WIDTH-1:0]   filt_image_width,
  output logic [DIM_WIDTH-1:0]   filt_image_height,
  input  logic                   filt_frame_sync_out,
  input  logic [7:0]             filt_data_out,
  output logic                   out_valid,
  output logic                   out_sof,
  output logic [7:0]             out_data,
  output logic                   busy,
  output logic                   done,
  output logic                   underrun,
  output logic                   timeout_err
);
  import conv_seq_pkg::*;

  localparam int PW = pix_cnt_width(DIM_WIDTH);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 2);

  seq_state_e             r_state, w_next;
  logic [COEFF_WIDTH-1:0] r_bank [NUM_COEFFS];
  logic [4:0]             r_k;
  logic [DIM_WIDTH-1:0]   r_w, r_h;
  logic [7:0]             r_nf, r_frame_cnt;
  logic [PW-1:0]          r_pix_cnt, r_total_m1;
  logic [TW-1:0]          r_to_cnt;
  logic                   r_data_valid_sync;
  logic [7:0]             r_data_in;
  logic                   r_done, r_underrun, r_timeout;

  logic [PW-1:0]          w_wp1, w_hp1, w_total_m1;
  logic                   w_start_ok, w_last_pix, w_last_frame, w_frames_all, w_timeout;
  logic                   w_out_active, w_out_start;
  logic [7:0]             w_frames_done;

  assign w_wp1       = PW'(img_width_m1) + PW'(1);
  assign w_hp1       = PW'(img_height_m1) + PW'(1);
  assign w_total_m1  = w_wp1 * w_hp1 - PW'(1);

  assign w_start_ok   = (r_state == IDLE) && start && (num_frames != 8'd0);
  assign w_last_pix   = (r_pix_cnt == r_total_m1);
  assign w_last_frame = (r_frame_cnt == r_nf - 8'd1);
  assign w_frames_all = (w_frames_done == r_nf) && !w_out_active;
  // The counter starts at 1 on DRAIN entry so it counts the entry cycle as waited.
  assign w_timeout    = (r_to_cnt > TW'(DRAIN_TIMEOUT)) && !w_out_active && !w_out_start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (w_start_ok) w_next = LOAD;
      LOAD:     if (r_k == 5'(NUM_COEFFS - 1)) w_next = LOAD_GAP;
      LOAD_GAP: w_next = STREAM;
      STREAM:   if (w_last_pix && w_last_frame) w_next = DRAIN;
      DRAIN:    if (w_frames_all || w_timeout) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_COEFFS; i++) r_bank[i] <= '0;
      r_k               <= '0;
      r_w               <= '0;
      r_h               <= '0;
      r_nf              <= '0;
      r_frame_cnt       <= '0;
      r_pix_cnt         <= '0;
      r_total_m1        <= '0;
      r_to_cnt          <= '0;
      r_data_valid_sync <= 1'b0;
      r_data_in         <= '0;
      r_done            <= 1'b0;
      r_underrun        <= 1'b0;
      r_timeout         <= 1'b0;
    end else begin
      r_done            <= 1'b0;
      r_data_in         <= (r_state == STREAM && src_valid) ? src_data : 8'd0;
      r_data_valid_sync <= (r_state == STREAM) && (r_pix_cnt == '0);
      unique case (r_state)
        IDLE: begin
          if (cfg_we && cfg_addr < 5'(NUM_COEFFS)) r_bank[cfg_addr] <= cfg_wdata;
          if (start && num_frames == 8'd0) begin
            r_done <= 1'b1;
          end else if (w_start_ok) begin
            r_w         <= img_width_m1;
            r_h         <= img_height_m1;
            r_nf        <= num_frames;
            r_total_m1  <= w_total_m1;
            r_underrun  <= 1'b0;
            r_timeout   <= 1'b0;
            r_k         <= '0;
            r_pix_cnt   <= '0;
            r_frame_cnt <= '0;
          end
        end
        LOAD: r_k <= r_k + 5'd1;
        STREAM: begin
          if (!src_valid) r_underrun <= 1'b1;
          if (w_last_pix) begin
            r_pix_cnt   <= '0;
            r_frame_cnt <= r_frame_cnt + 8'd1;
          end else begin
            r_pix_cnt <= r_pix_cnt + PW'(1);
          end
          if (w_last_pix && w_last_frame) r_to_cnt <= TW'(1);
        end
        DRAIN: begin
          if (w_out_start || w_out_active) r_to_cnt <= '0;
          else                             r_to_cnt <= r_to_cnt + TW'(1);
          if (w_frames_all) begin
            r_done <= 1'b1;
          end else if (w_timeout) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  conv_out_framer #(
    .DIM_WIDTH (DIM_WIDTH),
    .PW        (PW)
  ) u_framer (
    .clk           (clk),
    .reset         (reset),
    .i_en          (r_state != IDLE),
    .i_clear       (w_start_ok),
    .i_total_m1    (r_total_m1),
    .i_sync        (filt_frame_sync_out),
    .i_data        (filt_data_out),
    .o_valid       (out_valid),
    .o_sof         (out_sof),
    .o_data        (out_data),
    .o_active      (w_out_active),
    .o_start       (w_out_start),
    .o_frames_done (w_frames_done)
  );

  assign src_ready          = (r_state == STREAM);
  assign filt_config_load   = (r_state == LOAD);
  assign filt_coeff_in      = (r_state == LOAD) ? r_bank[r_k] : '0;
  assign filt_frame_sync_in = r_data_valid_sync;
  assign filt_data_in       = r_data_in;
  assign filt_image_width   = r_w;
  assign filt_image_height  = r_h;
  assign busy               = (r_state != IDLE);
  assign done               = r_done;
  assign underrun           = r_underrun;
  assign timeout_err        = r_timeout;

endmodule

// File: tb/tb_conv_filter_sequencer.sv
// tb/tb_conv_filter_sequencer.sv - self-checking bench for conv_filter_sequencer
module tb_conv_filter_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic        start = 1'b0;
  logic [7:0]  num_frames = '0;
  logic [9:0]  img_width_m1 = '0;
  logic [9:0]  img_height_m1 = '0;
  logic        src_valid = 1'b0;
  logic [7:0]  src_data = '0;
  logic        src_ready;
  logic        filt_config_load;
  logic [15:0] filt_coeff_in;
  logic        filt_frame_sync_in;
  logic [7:0]  filt_data_in;
  logic [9:0]  filt_image_width;
  logic [9:0]  filt_image_height;
  logic        filt_frame_sync_out = 1'b0;
  logic [7:0]  filt_data_out = '0;
  logic        out_valid, out_sof;
  logic [7:0]  out_data;
  logic        busy, done, underrun, timeout_err;

  conv_filter_sequencer dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .num_frames(num_frames), .img_width_m1(img_width_m1),
    .img_height_m1(img_height_m1), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .filt_config_load(filt_config_load), .filt_coeff_in(filt_coeff_in),
    .filt_frame_sync_in(filt_frame_sync_in), .filt_data_in(filt_data_in),
    .filt_image_width(filt_image_width), .filt_image_height(filt_image_height),
    .filt_frame_sync_out(filt_frame_sync_out), .filt_data_out(filt_data_out),
    .out_valid(out_valid), .out_sof(out_sof), .out_data(out_data), .busy(busy), .done(done),
    .underrun(underrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: coefficient bank as seen by host writes, and the pixel stream content.
  logic [15:0] exp_bank [25];
  int tot = 1, exp_nf = 0, drop_lo = -1, drop_hi = -1;

  function automatic logic [7:0] pix(input int i);
    return 8'((i * 7 + 13) % 256);
  endfunction

  function automatic logic [7:0] exp_pix(input int o);
    return (o >= drop_lo && o <= drop_hi) ? 8'd0 : pix(o);
  endfunction

  // Filter model: echoes sync/data with a programmable latency.
  logic [8:0] pipe [16];
  int lat = 1;
  bit echo_sync = 1'b1;
  initial for (int i = 0; i < 16; i++) pipe[i] = '0;
  always @(negedge clk) begin
    for (int i = 15; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = {filt_frame_sync_in, filt_data_in};
    filt_frame_sync_out = echo_sync & pipe[lat-1][8];
    filt_data_out       = pipe[lat-1][7:0];
  end

  // Pixel source: presents pixel src_idx whenever the sequencer is consuming.
  int src_idx = 0;
  always @(negedge clk) begin
    if (src_ready) begin
      if (src_idx >= drop_lo && src_idx <= drop_hi) begin
        src_valid = 1'b0;
        src_data  = 8'hA5;
      end else begin
        src_valid = 1'b1;
        src_data  = pix(src_idx);
      end
      src_idx++;
    end else begin
      src_valid = 1'b1;
      src_data  = 8'h5A;
    end
  end

  // Compare process.
  int cyc = 0;
  int load_cnt, out_cnt, sof_cnt, done_cnt, sync_cnt;
  int last_load_cyc, first_ready_cyc, drain_cyc, last_sync_cyc, last_valid_cyc, done_cyc, start_cyc;
  logic [15:0] seen_coeff [25];
  bit prev_ready = 1'b0;

  task automatic clear_mon();
    load_cnt = 0; out_cnt = 0; sof_cnt = 0; done_cnt = 0; sync_cnt = 0;
    last_load_cyc = -1; first_ready_cyc = -1; drain_cyc = -1; last_sync_cyc = -1;
    last_valid_cyc = -1; done_cyc = -1; start_cyc = -1;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (start && !busy) start_cyc = cyc;
      if (filt_config_load) begin
        if (load_cnt < 25) begin
          chk("coeff_value", filt_coeff_in, exp_bank[load_cnt]);
          seen_coeff[load_cnt] = filt_coeff_in;
        end
        last_load_cyc = cyc;
        load_cnt++;
      end
      if (src_ready && !prev_ready && first_ready_cyc < 0) first_ready_cyc = cyc;
      if (!src_ready && prev_ready) drain_cyc = cyc;
      if (filt_frame_sync_in) begin
        if (sync_cnt > 0) chk("sync_spacing", cyc - last_sync_cyc, tot);
        last_sync_cyc = cyc;
        sync_cnt++;
      end
      if (out_valid) begin
        chk("out_data", out_data, exp_pix(out_cnt));
        chk("out_sof", out_sof, (out_cnt % tot) == 0);
        if (out_sof) sof_cnt++;
        out_cnt++;
        last_valid_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_ready = src_ready;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_coeff(input int a, input int v);
    cfg_we = 1'b1; cfg_addr = 5'(a); cfg_wdata = 16'(v);
    if (!busy && a < 25) exp_bank[a] = 16'(v);
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input int wm1, input int hm1, input int nf, input int l,
                           input bit es, input int dlo, input int dhi);
    tick(1);
    tot = (wm1 + 1) * (hm1 + 1); exp_nf = nf; lat = l; echo_sync = es;
    drop_lo = dlo; drop_hi = dhi; src_idx = 0;
    clear_mon();
    img_width_m1 = 10'(wm1); img_height_m1 = 10'(hm1); num_frames = 8'(nf); start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_cnt == 0; k++) tick(1);
    chk("done_seen", done_cnt > 0, 1);
    tick(3);
  endtask

  task automatic check_normal_run();
    chk("done_count", done_cnt, 1);
    chk("load_count", load_cnt, 25);
    chk("ready_after_gap", first_ready_cyc - last_load_cyc, 2);
    chk("sync_with_pix0", last_sync_cyc >= 0 ? 1 : 0, 1);
    chk("sync_count", sync_cnt, exp_nf);
    chk("pixels_consumed", src_idx, tot * exp_nf);
    chk("out_count", out_cnt, tot * exp_nf);
    chk("sof_count", sof_cnt, exp_nf);
    chk("done_after_last_valid", done_cyc - last_valid_cyc, 1);
    chk("busy_after_done", busy, 0);
  endtask

  int first_sync_rel;

  initial begin
    for (int i = 0; i < 25; i++) begin exp_bank[i] = '0; seen_coeff[i] = '0; end
    clear_mon();

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_cfg_load", filt_config_load, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", {underrun, timeout_err}, 0);
    reset = 1'b1;
    tick(2);

    // Load sequence, 4x4, one frame; busy start/cfg_we must be ignored
    for (int k = 0; k < 25; k++) write_coeff(k, k * 3 + 1);
    write_coeff(27, 16'hBEEF);
    start_run(3, 3, 1, 3, 1'b1, -1, -1);
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = 16'd999;
    start = 1'b1; num_frames = 8'd5; img_width_m1 = 10'd7;
    tick(1);
    cfg_we = 1'b0; start = 1'b0;
    wait_done(500);
    check_normal_run();
    chk("coeff_first_lit", seen_coeff[0], 1);
    chk("coeff_last_lit", seen_coeff[24], 73);
    chk("dims_latched", filt_image_width, 3);
    chk("underrun_clean", underrun, 0);

    // num_frames = 0
    clear_mon();
    num_frames = 8'd0; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    chk("nf0_done_count", done_cnt, 1);
    chk("nf0_done_next", done_cyc - start_cyc, 1);
    chk("nf0_no_load", load_cnt, 0);
    chk("nf0_idle", busy, 0);

    // Back-to-back 128x128 x2; coefficients must be unchanged by the busy write
    start_run(127, 127, 2, 5, 1'b1, -1, -1);
    wait_done(40000);
    check_normal_run();
    chk("b2b_out_lit", out_cnt, 32768);
    chk("b2b_coeff0_lit", seen_coeff[0], 1);
    chk("b2b_underrun", underrun, 0);

    // Underrun: pixels 5..7 dropped
    start_run(3, 3, 2, 2, 1'b1, 5, 7);
    wait_done(500);
    check_normal_run();
    chk("underrun_set", underrun, 1);
    tick(5);
    chk("underrun_sticky", underrun, 1);

    // Drain timeout: filter never reports frame sync
    start_run(1, 1, 1, 1, 1'b0, -1, -1);
    chk("underrun_cleared", underrun, 0);
    wait_done(2000);
    chk("to_done_count", done_cnt, 1);
    chk("to_latency_lit", done_cyc - drain_cyc, 1025);
    chk("to_flag", timeout_err, 1);
    chk("to_no_output", out_cnt, 0);
    chk("to_idle", busy, 0);

    // Async reset mid-STREAM
    start_run(7, 7, 1, 2, 1'b1, -1, -1);
    chk("to_cleared", timeout_err, 0);
    for (int k = 0; k < 200 && src_idx < 20; k++) tick(1);
    chk("in_stream", src_ready, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_src_ready", src_ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data_in", {filt_frame_sync_in, filt_data_in}, 0);
    chk("arst_out", {out_valid, out_sof, out_data}, 0);
    chk("arst_cfg", {filt_config_load, filt_coeff_in}, 0);
    for (int i = 0; i < 25; i++) exp_bank[i] = '0;
    tick(2);
    reset = 1'b1;
    tick(2);

    // Bank must be cleared after reset
    start_run(1, 1, 1, 4, 1'b1, -1, -1);
    wait_done(500);
    check_normal_run();
    chk("cleared_coeff_lit", seen_coeff[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
